// File: rtl/gst_snd_dma_ctrl.sv
// rtl/gst_snd_dma_ctrl.sv - STE DMA-sound frame sequencer with fetch strobe and end-of-frame flags
module gst_snd_dma_ctrl #(
    parameter int SLOAD_LEN = 2
) (
    input  logic        clk32,
    input  logic        resb,
    input  logic        CS,
    input  logic        RW,
    input  logic [3:0]  A,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    input  logic        SREQ,
    input  logic        SLOT,
    output logic [22:0] ADDR,
    output logic        SLOAD_N,
    output logic        SINT,
    output logic        SACTIVE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FETCH = 3'd3,
        S_POST  = 3'd4
    } state_t;

    localparam logic [2:0] FETCH_LAST = 3'(SLOAD_LEN - 1);

    state_t      state;
    state_t      state_nx;
    logic [2:0]  fcnt;
    logic        cs_q;
    logic        wr;
    logic [1:0]  ctrl;
    logic [22:0] start_r;
    logic [22:0] end_r;
    logic [22:0] cnt;
    logic [22:0] end_w;
    logic [22:0] addr_r;
    logic [22:0] cnt_inc;
    logic        empty;
    logic        frame_end;
    logic        clr_all;
    logic        clr_en;
    logic        din_unused;

    // Only the low byte of the CPU bus carries register data
    assign din_unused = ^DIN[15:8];

    // Writes fire once per CS assertion, on its first cycle
    assign wr        = CS & ~RW & ~cs_q;
    assign empty     = (start_r >= end_r);
    assign cnt_inc   = cnt + 23'd1;
    assign frame_end = (cnt_inc == end_w);
    assign ADDR      = addr_r;

    // Remember CS for the write-strobe edge detector
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) cs_q <= 1'b0;
        else       cs_q <= CS;
    end

    // CPU-visible registers; a CPU write to CTRL beats the sequencer's own clear
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            ctrl    <= 2'b00;
            start_r <= '0;
            end_r   <= '0;
        end else begin
            if (wr && A == 4'd0) ctrl <= DIN[1:0];
            else if (clr_all)    ctrl <= 2'b00;
            else if (clr_en)     ctrl[0] <= 1'b0;
            if (wr) begin
                case (A)
                    4'd1:    start_r[22:15] <= DIN[7:0];
                    4'd2:    start_r[14:7]  <= DIN[7:0];
                    4'd3:    start_r[6:0]   <= DIN[7:1];
                    4'd7:    end_r[22:15]   <= DIN[7:0];
                    4'd8:    end_r[14:7]    <= DIN[7:0];
                    4'd9:    end_r[6:0]     <= DIN[7:1];
                    default: ;
                endcase
            end
        end
    end

    // Sequencer state and strobe-length counter
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            state <= S_IDLE;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nx;
            fcnt  <= (state == S_FETCH) ? fcnt + 3'd1 : 3'd0;
        end
    end

    // Next-state selection; an in-flight fetch always runs to completion
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ctrl[0]) state_nx = S_LOAD;
            S_LOAD:  state_nx = empty ? S_IDLE : S_RUN;
            S_RUN: begin
                if (!ctrl[0])          state_nx = S_IDLE;
                else if (SREQ && SLOT) state_nx = S_FETCH;
            end
            S_FETCH: if (fcnt == FETCH_LAST) state_nx = S_POST;
            S_POST: begin
                if (!ctrl[0])       state_nx = S_IDLE;
                else if (frame_end) state_nx = ctrl[1] ? S_LOAD : S_IDLE;
                else                state_nx = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes and flags decoded from the current state
    always_comb begin
        SLOAD_N = 1'b1;
        SINT    = 1'b0;
        SACTIVE = 1'b0;
        clr_all = 1'b0;
        clr_en  = 1'b0;
        case (state)
            S_LOAD: begin
                // An empty frame drops the whole control word, loop included
                SINT    = empty;
                SACTIVE = ~empty;
                clr_all = empty;
            end
            S_RUN:   SACTIVE = 1'b1;
            S_FETCH: begin
                SACTIVE = 1'b1;
                SLOAD_N = 1'b0;
            end
            S_POST: begin
                SACTIVE = 1'b1;
                SINT    = frame_end;
                clr_en  = frame_end & ~ctrl[1];
            end
            default: ;
        endcase
    end

    // Working counter, frame end copy and fetch address
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            cnt    <= '0;
            end_w  <= '0;
            addr_r <= '0;
        end else begin
            if (state == S_LOAD) begin
                cnt   <= start_r;
                end_w <= end_r;
            end
            if (state == S_RUN && state_nx == S_FETCH) addr_r <= cnt;
            if (state == S_POST) cnt <= cnt_inc;
        end
    end

    // Register read mux; byte registers sit in the low byte
    always_comb begin
        DOUT = 16'h0000;
        if (CS && RW) begin
            case (A)
                4'd0:    DOUT = {14'd0, ctrl};
                4'd1:    DOUT = {8'd0, start_r[22:15]};
                4'd2:    DOUT = {8'd0, start_r[14:7]};
                4'd3:    DOUT = {8'd0, start_r[6:0], 1'b0};
                4'd4:    DOUT = {8'd0, cnt[22:15]};
                4'd5:    DOUT = {8'd0, cnt[14:7]};
                4'd6:    DOUT = {8'd0, cnt[6:0], 1'b0};
                4'd7:    DOUT = {8'd0, end_r[22:15]};
                4'd8:    DOUT = {8'd0, end_r[14:7]};
                4'd9:    DOUT = {8'd0, end_r[6:0], 1'b0};
                default: DOUT = 16'h0000;
            endcase
        end
    end

endmodule
